lfsr_stream: RTL and testbench
==============================

Name: lfsr_stream

Overview:
- Parametrised Fibonacci LFSR pseudo-random word generator. Successor to the fixed 4-bit single-bit LFSR.
- Width and feedback polynomial are generic. Serial output bits are packed into OUT_BITS-wide words and delivered over a valid/ready handshake.
- Adds zero-seed lock-up protection and a period-wrap indicator.
- Sits between SRAM test/counter logic and any consumer needing a pseudo-random data or address stream.

Parameters:
- WIDTH, 16, LFSR state width in bits (legal range 3..32).
- TAPS, 16'hD008, feedback mask, WIDTH bits wide; feedback = XOR of state bits where mask = 1.
- DEFAULT_SEED, 16'h0001, WIDTH bits wide; state after reset and replacement for an all-zero seed. Must be nonzero.
- OUT_BITS, 8, output word width (legal range 1..32).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- SEED  in  WIDTH  seed value.
- LOAD  in  1  load SEED into state (single-cycle pulse or level).
- ENABLE  in  1  permit the LFSR to advance.
- DOUT  out  OUT_BITS  packed output word.
- DOUT_VALID  out  1  DOUT holds a complete word.
- DOUT_READY  in  1  consumer accepts the word.
- LOCKUP  out  1  one-cycle pulse: all-zero seed was replaced.
- PERIOD_WRAP  out  1  one-cycle pulse: state returned to the last loaded seed.

Behaviour:
- Reset (RST = 0, asynchronous):
  - state = DEFAULT_SEED and seed_reg = DEFAULT_SEED.
  - bit counter = 0; DOUT = 0; DOUT_VALID = 0; LOCKUP = 0; PERIOD_WRAP = 0.
  - FSM enters FILL.
- Step definition:
  - fb = ^(state & TAPS).
  - next state = {state[WIDTH-2:0], fb}.
  - The bit emitted on each step is fb.
  - Emitted bits shift into the collection register from the LSB side: col <= {col[OUT_BITS-2:0], fb}. The first emitted bit ends up in DOUT[OUT_BITS-1].
- FSM state FILL:
  - Each cycle with ENABLE = 1: perform one step and increment the bit counter.
  - When the counter reaches OUT_BITS-1 and a step occurs: DOUT <= completed word, DOUT_VALID <= 1, counter <= 0, go to HOLD.
  - With ENABLE = 0: state, counter and collection register hold.
- FSM state HOLD:
  - The LFSR does not step. DOUT and DOUT_VALID are stable.
  - When DOUT_VALID = 1 and DOUT_READY = 1 at a clock edge: DOUT_VALID <= 0 and go to FILL.
  - Stepping resumes the following cycle; there is no same-cycle refill.
- Latency: first word is valid OUT_BITS enabled cycles after reset or load. Maximum throughput is one word per OUT_BITS+1 cycles.
- LOAD (synchronous, highest priority; overrides ENABLE and the handshake):
  - state <= SEED and seed_reg <= SEED.
  - Counter and collection register clear; DOUT_VALID <= 0; FSM goes to FILL.
  - No step occurs that cycle. DOUT keeps its last value but is not valid.
- Zero seed: if LOAD = 1 and SEED == 0, load DEFAULT_SEED into both state and seed_reg instead, and pulse LOCKUP for one cycle. LOCKUP is otherwise 0.
- Lock-up guard: if the state is ever all-zero (TAPS error or upset), the next step loads DEFAULT_SEED instead of shifting and pulses LOCKUP.
- PERIOD_WRAP: one-cycle pulse in the cycle after any step whose next state equals seed_reg. It is not asserted on LOAD itself.
- Simultaneous LOAD and DOUT_READY: LOAD wins. The pending word is discarded and does not count as a transfer.
- Reset mid-word: all partial collection data is lost. Reset has no effect on anything outside this block.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset with WIDTH=4, TAPS=4'hC, OUT_BITS=4, ENABLE=1, DOUT_READY=1:
  - DOUT_VALID rises after 4 cycles.
  - State sequence from 4'h1 is 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
  - PERIOD_WRAP pulses once per 15 steps.
- LOAD with SEED=0 (WIDTH=4):
  - LOCKUP pulses once; state = DEFAULT_SEED.
  - The subsequent sequence is identical to the post-reset sequence.
- Backpressure: hold DOUT_READY=0 for 10 cycles once DOUT_VALID=1 -> DOUT is stable, state does not advance, and no words are lost. Release -> the next word follows OUT_BITS+1 cycles after acceptance.
- LOAD of 4'h5 issued mid-word (counter = 2) -> DOUT_VALID drops, counter resets, and the next word is built from the steps starting at 5 (state sequence B,7,F,E).
- ENABLE toggling 1-0-1 during FILL -> the word content equals the same word with ENABLE held at 1; only its timing stretches.
- Defaults (WIDTH=16, TAPS=16'hD008): run 65535 steps from 16'h0001 -> exactly one PERIOD_WRAP, at step 65535, and no all-zero state is ever reached.

Source files
------------

// File: rtl/lfsr_stream_if.sv
// Word-stream bundle between the LFSR generator (master) and its consumer (slave).
// Handshake: a word transfers on a rising clk edge where dout_valid and dout_ready are both 1.
interface lfsr_stream_if #(
  parameter int WIDTH    = 16,
  parameter int OUT_BITS = 8
);
  logic [WIDTH-1:0]    seed;
  logic                load;
  logic                enable;
  logic [OUT_BITS-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                lockup;
  logic                period_wrap;
  // Debug visibility: current LFSR state and FSM state (1 = HOLD).
  logic [WIDTH-1:0]    dbg_state;
  logic                dbg_hold;

  modport master (
    input  seed, load, enable, dout_ready,
    output dout, dout_valid, lockup, period_wrap, dbg_state, dbg_hold
  );

  modport slave (
    output seed, load, enable, dout_ready,
    input  dout, dout_valid, lockup, period_wrap, dbg_state, dbg_hold
  );
endinterface

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR that packs its feedback bits into OUT_BITS-wide words,
// with zero-seed/zero-state recovery and a pulse when the loaded seed recurs.
module lfsr_stream #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hD008,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001,
  parameter int               OUT_BITS     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  lfsr_stream_if.master bus
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} fsm_e;

  localparam int            CW   = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_BITS - 1);

  fsm_e                fsm_q, fsm_d;
  logic [WIDTH-1:0]    state_q, state_d;
  logic [WIDTH-1:0]    seed_q, seed_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUT_BITS-1:0] col_q, col_d;
  logic [OUT_BITS-1:0] dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                lockup_q, lockup_d;
  logic                wrap_q, wrap_d;

  logic                fb;
  logic [WIDTH-1:0]    step_nx;
  logic [OUT_BITS-1:0] col_sh;

  always_comb begin
    fb      = ^(state_q & TAPS);
    // An all-zero state can never leave zero by shifting, so it is replaced outright.
    step_nx = (state_q == '0) ? DEFAULT_SEED : {state_q[WIDTH-2:0], fb};
    col_sh    = col_q << 1;
    col_sh[0] = fb;

    fsm_d    = fsm_q;
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;

    if (bus.load) begin
      if (bus.seed == '0) begin
        state_d  = DEFAULT_SEED;
        seed_d   = DEFAULT_SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = bus.seed;
        seed_d  = bus.seed;
      end
      cnt_d   = '0;
      col_d   = '0;
      valid_d = 1'b0;
      fsm_d   = FILL;
    end else begin
      case (fsm_q)
        FILL: begin
          if (bus.enable) begin
            state_d  = step_nx;
            lockup_d = (state_q == '0);
            wrap_d   = (step_nx == seed_q);
            col_d    = col_sh;
            if (cnt_q == LAST) begin
              dout_d  = col_sh;
              valid_d = 1'b1;
              cnt_d   = '0;
              fsm_d   = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Refill starts on the cycle after acceptance, never in the same one.
          if (valid_q && bus.dout_ready) begin
            valid_d = 1'b0;
            fsm_d   = FILL;
          end
        end
        default: fsm_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= FILL;
      state_q  <= DEFAULT_SEED;
      seed_q   <= DEFAULT_SEED;
      cnt_q    <= '0;
      col_q    <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = valid_q;
  assign bus.lockup      = lockup_q;
  assign bus.period_wrap = wrap_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_hold    = (fsm_q == HOLD);

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: a 4-bit instance driven by directed and random steps against
// a word-level model, plus a free-running default-size instance checked over a full period.
module tb_lfsr_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_stream_if #(.WIDTH(4),  .OUT_BITS(4)) if4 ();
  lfsr_stream_if #(.WIDTH(16), .OUT_BITS(8)) if16 ();

  lfsr_stream #(.WIDTH(4), .TAPS(4'hC), .DEFAULT_SEED(4'h1), .OUT_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.master)
  );

  lfsr_stream dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  logic [3:0] seq_tab[15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] ld5_tab[4]  = '{4'hB, 4'h7, 4'hF, 4'hE};
  bit         en_pat[7]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  // Reference model of the 4-bit instance (WIDTH=4, TAPS=C, seed default 1, 4-bit words)
  int m_state = 1, m_seed = 1, m_cnt = 0, m_word = 0, m_dout = 0;
  bit m_valid = 0, m_lock = 0, m_wrap = 0;

  function automatic int par(input int v);
    return $countones(v) % 2;
  endfunction

  function automatic logic [15:0] nxt16(input logic [15:0] s);
    if (s == 16'h0) return 16'h0001;
    return {s[14:0], 1'(par(int'(s & 16'hD008)))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit ld, input int sd, input bit en, input bit rd);
    int b;
    int nx;
    m_lock = 0;
    m_wrap = 0;
    if (ld) begin
      if (sd % 16 == 0) begin
        m_state = 1; m_seed = 1; m_lock = 1;
      end else begin
        m_state = sd % 16; m_seed = m_state;
      end
      m_cnt  = 0;
      m_word = 0;
      if (m_valid && exp_q.size() > 0) void'(exp_q.pop_back());
      m_valid = 0;
    end else if (m_valid) begin
      if (rd) m_valid = 0;
    end else if (en) begin
      b       = par(m_state & 'hC);
      nx      = (m_state == 0) ? 1 : (m_state * 2 + b) % 16;
      m_lock  = (m_state == 0);
      m_wrap  = (nx == m_seed);
      m_state = nx;
      m_word  = (m_word * 2 + b) % 16;
      m_cnt++;
      if (m_cnt == 4) begin
        m_cnt   = 0;
        m_valid = 1;
        m_dout  = m_word;
        exp_q.push_back(m_word[3:0]);
      end
    end
  endtask

  // One clock of the 4-bit instance: drive, clock, update model, check every output.
  task automatic cyc(input bit ld, input int sd, input bit en, input bit rd);
    bit         xfer;
    logic [3:0] got;
    logic [3:0] want;
    if4.load       = ld;
    if4.seed       = sd[3:0];
    if4.enable     = en;
    if4.dout_ready = rd;
    xfer = !ld && m_valid && rd;
    got  = if4.dout;
    if (xfer) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        want = exp_q.pop_front();
        chk("sb_word", got, want);
      end
    end
    @(posedge clk);
    model_step(ld, sd, en, rd);
    @(negedge clk);
    chk("valid",  if4.dout_valid,  m_valid);
    chk("dout",   if4.dout,        m_dout);
    chk("state",  if4.dbg_state,   m_state);
    chk("lockup", if4.lockup,      m_lock);
    chk("wrap",   if4.period_wrap, m_wrap);
    chk("hold",   if4.dbg_hold,    m_valid);
  endtask

  // 18 cycles with enable/ready high: 15 steps (3 handshake stalls) walk the full period.
  task automatic run_seq(input string tag);
    int         k = 0;
    int         wraps = 0;
    logic [3:0] prev;
    for (int i = 1; i <= 18; i++) begin
      prev = if4.dbg_state;
      cyc(0, 0, 1, 1);
      if (if4.dbg_state != prev) begin
        if (k < 15) chk({tag, "_seq"}, if4.dbg_state, seq_tab[k]);
        k++;
      end
      wraps += int'(if4.period_wrap);
      if (i == 3) chk({tag, "_lat_early"}, if4.dout_valid, 1'b0);
      if (i == 4) begin
        chk({tag, "_lat_valid"}, if4.dout_valid, 1'b1);
        chk({tag, "_first_word"}, if4.dout, 4'h3);
      end
    end
    chk({tag, "_steps"}, k, 15);
    chk({tag, "_wraps"}, wraps, 1);
  endtask

  // Free-running monitor of the default-size instance
  logic [15:0] p16 = 16'h0001;
  int s16 = 0, bad16 = 0, w16_cnt = 0, w16_at = 0, w16_stray = 0;
  bit zero16 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if16.dbg_state != p16) begin
        s16 <= s16 + 1;
        if (if16.dbg_state != nxt16(p16)) bad16 <= bad16 + 1;
        if (if16.dbg_state == 16'h0) zero16 <= 1'b1;
        if (if16.period_wrap && s16 < 65535) begin
          w16_cnt <= w16_cnt + 1;
          w16_at  <= s16 + 1;
        end
      end else if (if16.period_wrap) begin
        w16_stray <= w16_stray + 1;
      end
      p16 <= if16.dbg_state;
    end
  end

  initial begin
    int n;
    int g;
    bit ld;
    int sd;

    if4.load = 0; if4.seed = 0; if4.enable = 0; if4.dout_ready = 0;
    if16.load = 0; if16.seed = 0; if16.enable = 1; if16.dout_ready = 1;

    repeat (3) @(negedge clk);
    chk("rst_valid",  if4.dout_valid,  1'b0);
    chk("rst_dout",   if4.dout,        4'h0);
    chk("rst_state",  if4.dbg_state,   4'h1);
    chk("rst_lockup", if4.lockup,      1'b0);
    chk("rst_wrap",   if4.period_wrap, 1'b0);
    chk("rst_hold",   if4.dbg_hold,    1'b0);
    chk("rst16_state", if16.dbg_state, 16'h0001);
    chk("rst16_valid", if16.dout_valid, 1'b0);
    rst_n = 1'b1;

    run_seq("reset");

    // Zero seed replaced by the default, then identical sequence
    cyc(1, 0, 1, 1);
    chk("zseed_lockup", if4.lockup, 1'b1);
    chk("zseed_state",  if4.dbg_state, 4'h1);
    run_seq("zseed");

    // Backpressure: completed word and state freeze while ready is low
    cyc(0, 0, 1, 0);
    chk("bp_valid", if4.dout_valid, 1'b1);
    chk("bp_dout",  if4.dout, 4'h2);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0);
      chk("bp_hold_dout",  if4.dout, 4'h2);
      chk("bp_hold_state", if4.dbg_state, 4'h2);
      chk("bp_hold_valid", if4.dout_valid, 1'b1);
    end
    cyc(0, 0, 1, 1);
    n = 1;
    while (!if4.dout_valid && n < 20) begin
      cyc(0, 0, 1, 1);
      n++;
    end
    chk("bp_next_latency", n, 5);
    chk("bp_next_word", if4.dout, 4'h6);

    // LOAD of 5 with two bits of a word already collected
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 5, 1, 0);
    chk("ld5_valid", if4.dout_valid, 1'b0);
    chk("ld5_state", if4.dbg_state, 4'h5);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      chk("ld5_seq", if4.dbg_state, ld5_tab[i]);
    end
    chk("ld5_word_valid", if4.dout_valid, 1'b1);
    chk("ld5_word", if4.dout, 4'hE);

    // LOAD beats a simultaneous ready: the pending word is dropped
    cyc(1, 9, 1, 1);
    chk("ld_vs_rdy_valid", if4.dout_valid, 1'b0);
    chk("ld_vs_rdy_state", if4.dbg_state, 4'h9);

    // Enable gaps stretch timing but not content
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, en_pat[i], 0);
    chk("en_gap_valid", if4.dout_valid, 1'b1);
    chk("en_gap_word", if4.dout, 4'h3);
    cyc(0, 0, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 19) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      cyc(ld, sd, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // Full period of the default polynomial
    g = 0;
    while (s16 < 65535 && g < 90000) begin
      @(negedge clk);
      g++;
    end
    chk("p16_steps_reached", s16 >= 65535, 1'b1);
    chk("p16_wrap_count", w16_cnt, 1);
    chk("p16_wrap_step",  w16_at, 65535);
    chk("p16_wrap_stray", w16_stray, 0);
    chk("p16_zero_state", zero16, 1'b0);
    chk("p16_step_errors", bad16, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
